// File: rtl/bus_cycle_ctrl.sv
// Memory bus-cycle controller for the 65C02/65C816 bus.
// It turns the phaser strobes into latched address, chip selects and read/write strobes.
module bus_cycle_ctrl #(
  parameter int SRAM_WS = 0,
  parameter int NORA_WS = 1,
  parameter int VERA_WS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch_ad,
  input  logic        setup_cs,
  input  logic        release_wr,
  input  logic        release_cs,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_db,
  input  logic        cpu_rwn,
  input  logic        m24,
  output logic [23:0] mem_addr,
  output logic        sram_csn,
  output logic        vera_csn,
  output logic        nora_stb,
  output logic        nora_rwn,
  output logic        mrdn,
  output logic        mwrn,
  output logic [1:0]  s4_ext_o,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  typedef enum logic [1:0] {TGT_SRAM, TGT_NORA, TGT_VERA} tgt_t;

  localparam logic [1:0] SRAM_EXT = (SRAM_WS > 3) ? 2'd3 : 2'(SRAM_WS);
  localparam logic [1:0] NORA_EXT = (NORA_WS > 3) ? 2'd3 : 2'(NORA_WS);
  localparam logic [1:0] VERA_EXT = (VERA_WS > 3) ? 2'd3 : 2'(VERA_WS);

  state_t      state_reg, state_next;
  tgt_t        tgt_reg, tgt_in, tgt_cur;
  logic [7:0]  bank_in;
  logic [1:0]  ext_in;
  logic        rwn_cur;
  logic        restart_reg, restart_next;
  logic        proto_err_next;
  logic        sram_csn_next, vera_csn_next, mrdn_next, mwrn_next, nora_stb_next, busy_next;

  // Decode the incoming address so CS can assert on the same edge that latches it.
  always_comb begin
    bank_in = m24 ? cpu_db : 8'h00;
    tgt_in  = TGT_SRAM;
    ext_in  = SRAM_EXT;
    if (bank_in == 8'h00 && cpu_ab[15:5] == 11'h4F8) begin
      tgt_in = TGT_NORA;
      ext_in = NORA_EXT;
    end else if (bank_in == 8'h00 && cpu_ab[15:5] == 11'h4F9) begin
      tgt_in = TGT_VERA;
      ext_in = VERA_EXT;
    end
    tgt_cur = latch_ad ? tgt_in : tgt_reg;
    rwn_cur = latch_ad ? cpu_rwn : nora_rwn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= 24'h000000;
      nora_rwn <= 1'b1;
      tgt_reg  <= TGT_SRAM;
      s4_ext_o <= 2'd0;
    end else if (latch_ad) begin
      mem_addr <= {bank_in, cpu_ab};
      nora_rwn <= cpu_rwn;
      tgt_reg  <= tgt_in;
      s4_ext_o <= ext_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      restart_reg <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      restart_reg <= restart_next;
      proto_err   <= proto_err_next;
    end
  end

  // A setup_cs mid-cycle drops to IDLE for one cycle, then restarts from the new address.
  always_comb begin
    state_next     = state_reg;
    restart_next   = 1'b0;
    proto_err_next = proto_err;
    if (state_reg != IDLE && setup_cs) begin
      state_next     = IDLE;
      restart_next   = 1'b1;
      proto_err_next = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE:   if (setup_cs || restart_reg) state_next = SETUP;
        SETUP: begin
          if (release_cs) begin
            state_next     = IDLE;
            proto_err_next = 1'b1;
          end else begin
            state_next = ACCESS;
          end
        end
        ACCESS: begin
          if (release_cs)      state_next = IDLE;
          else if (release_wr) state_next = HOLD;
        end
        HOLD:   if (release_cs) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_next     = (state_next != IDLE);
    sram_csn_next = !(busy_next && tgt_cur == TGT_SRAM);
    vera_csn_next = !(busy_next && tgt_cur == TGT_VERA);
    mrdn_next     = !(busy_next && rwn_cur);
    mwrn_next     = !(state_next == ACCESS && !rwn_cur);
    nora_stb_next = (state_reg == SETUP) && (state_next == ACCESS) && (tgt_cur == TGT_NORA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_csn <= 1'b1;
      vera_csn <= 1'b1;
      mrdn     <= 1'b1;
      mwrn     <= 1'b1;
      nora_stb <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sram_csn <= sram_csn_next;
      vera_csn <= vera_csn_next;
      mrdn     <= mrdn_next;
      mwrn     <= mwrn_next;
      nora_stb <= nora_stb_next;
      busy     <= busy_next;
    end
  end

endmodule
